// File: rtl/add_seq.sv
// add_seq: multi-cycle adder summing one DIGIT-bit slice per clock with a registered carry.
module add_seq #(
  parameter int W = 32,
  parameter int DIGIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         Cout,
  output logic         overflow
);
  localparam int N = W / DIGIT;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0] a_q, b_q, result_q;
  logic c_q, cout_q, ovf_q;
  logic [DIGIT-1:0] a_sl, b_sl;
  logic [DIGIT:0] sum_d;
  logic msb_cin_d;
  // carry into the slice MSB recovered from its sum bit: s = a ^ b ^ cin
  always_comb begin
    a_sl = a_q[idx_q*DIGIT +: DIGIT];
    b_sl = b_q[idx_q*DIGIT +: DIGIT];
    sum_d = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, c_q};
    msb_cin_d = a_sl[DIGIT-1] ^ b_sl[DIGIT-1] ^ sum_d[DIGIT-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      result_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state_q == RUN) begin
      result_q[idx_q*DIGIT +: DIGIT] <= sum_d[DIGIT-1:0];
      c_q <= sum_d[DIGIT];
      idx_q <= idx_q + 1'b1;
      if (idx_q == IW'(N-1)) begin
        cout_q <= sum_d[DIGIT];
        ovf_q <= sum_d[DIGIT] ^ msb_cin_d;
        state_q <= DONE;
      end
    end else if (start) begin
      a_q <= A;
      b_q <= B;
      c_q <= Cin;
      idx_q <= '0;
      result_q <= '0;
      state_q <= RUN;
    end else begin
      state_q <= IDLE;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign result = result_q;
  assign Cout = cout_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_add_seq.sv
// tb_add_seq: scoreboard bench for add_seq against a plain-arithmetic reference model.
module tb_add_seq;
  localparam int LAT = 9;
  typedef struct {
    logic [31:0] r;
    logic co;
    logic ov;
    int due;
  } exp_t;
  logic clk = 0, rst = 1, start = 0, Cin = 0;
  logic [31:0] A = 0, B = 0;
  logic busy, done, Cout, overflow;
  logic [31:0] result;
  int cyc = 0, vectors = 0, miscompares = 0;
  exp_t sb[$];

  add_seq dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .result(result), .Cout(Cout), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic ci, input bit expect_done);
    logic [32:0] s;
    exp_t e;
    A = a;
    B = b;
    Cin = ci;
    start = 1;
    if (expect_done) begin
      s = {1'b0, a} + {1'b0, b} + 33'(ci);
      e.r = s[31:0];
      e.co = s[32];
      e.ov = (a[31] == b[31]) && (s[31] != a[31]);
      e.due = cyc + LAT;
      sb.push_back(e);
    end
  endtask

  task automatic single(input logic [31:0] a, input logic [31:0] b, input logic ci);
    @(negedge clk);
    issue(a, b, ci, 1);
    @(negedge clk);
    start = 0;
    repeat (LAT) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_done"}, 32'(done), 0);
    check({name, "_result"}, result, 0);
    check({name, "_cout"}, 32'(Cout), 0);
    check({name, "_ovf"}, 32'(overflow), 0);
  endtask

  // monitor: compares every done pulse with the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && sb.size() > 0 && cyc > sb[0].due) begin
      vectors++;
      miscompares++;
      $display("FAIL done_missing: no done by cycle %0d, expected at %0d", cyc, sb[0].due);
      void'(sb.pop_front());
    end
    if (!rst && done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_done: got done at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", 32'(cyc), 32'(e.due));
        check("result", result, e.r);
        check("cout", 32'(Cout), 32'(e.co));
        check("overflow", 32'(overflow), 32'(e.ov));
        check("busy_at_done", 32'(busy), 0);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    check_zero("reset");
    single(32'h00000001, 32'hFFFFFFFF, 0);
    single(32'h7FFFFFFF, 32'h00000001, 0);
    single(32'h80000000, 32'h80000000, 0);
    single(32'h00000000, 32'h00000000, 1);
    single(32'hFFFFFFFF, 32'h00000000, 1);
    // second start while busy must be ignored
    @(negedge clk);
    issue(5, 7, 0, 1);
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    issue(100, 100, 0, 0);
    @(negedge clk);
    start = 0;
    repeat (LAT + 3) @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    // back-to-back: start held through operation 1's done cycle
    @(negedge clk);
    issue(32'h12345678, 32'h11111111, 0, 1);
    repeat (LAT) @(negedge clk);
    issue(32'hFFFF0000, 32'h00010000, 0, 1);
    @(negedge clk);
    start = 0;
    repeat (LAT) @(negedge clk);
    // reset mid-operation discards the operation
    @(negedge clk);
    issue(32'hDEADBEEF, 32'h01234567, 0, 0);
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_zero("midrst");
    repeat (LAT + 2) @(negedge clk);
    single(3, 4, 0);
    // randomized operations, some back-to-back
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      issue($urandom, $urandom, 1'($urandom_range(1)), 1);
      @(negedge clk);
      start = 0;
      repeat (LAT - 1) @(negedge clk);
      if ($urandom_range(1) == 1) begin
        issue($urandom, $urandom, 1'($urandom_range(1)), 1);
        @(negedge clk);
        start = 0;
        repeat (LAT - 1) @(negedge clk);
      end
      @(negedge clk);
    end
    repeat (LAT + 3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/add_seq.md
# add_seq

Multi-cycle 32-bit adder in the ALU operations group: the additive counterpart of the ripple-borrow subtractor. Operands are latched on a start handshake and summed one DIGIT-bit slice per clock, with the carry held in a register between slices. The block returns sum, carry-out and signed overflow with a one-cycle done pulse. It serves datapaths that trade latency for a short carry chain.

## Interface
- W, 32: operand width; must be a multiple of DIGIT.
- DIGIT, 4: bits summed per cycle; the RUN phase lasts N = W/DIGIT cycles (8 at defaults).

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when the block is ready (IDLE or DONE).
- A  in  W  augend; latched on an accepted start.
- B  in  W  addend; latched on an accepted start.
- Cin  in  1  carry into bit 0; latched on an accepted start.
- busy  out  1  high throughout the RUN phase.
- done  out  1  one-cycle pulse; result, Cout and overflow are valid in that cycle.
- result  out  W  A + B + Cin, modulo 2^W.
- Cout  out  1  carry out of bit W-1.
- overflow  out  1  two's-complement overflow: carry into bit W-1 XOR carry out of bit W-1.

## Operation
- State machine IDLE, RUN, DONE.
  - IDLE: start=1 latches A, B and Cin, clears the digit index and the result register, then moves to RUN.
  - RUN: each edge adds slice [idx*DIGIT +: DIGIT] of the latched A and B plus the carry register. The sum slice is written into result and the slice carry-out goes back into the carry register; idx then increments. On the edge with idx = N-1 the block captures Cout and overflow and moves to DONE.
  - DONE lasts exactly one cycle with done=1.
    - start=1 in DONE: accepted exactly as in IDLE, giving back-to-back operation; next state RUN.
    - Otherwise next state IDLE.
- start while busy=1 is ignored. The latched operands do not change until the next accepted start.
- result, Cout and overflow hold their last values in IDLE until the next accepted start. The accepted start clears result on that edge.
- Overflow uses the carry into the MSB, taken from the final slice's internal carry at bit W-1. It is not derived from the sign of the result alone.
- Widths: the per-slice adder is DIGIT+1 bits wide, and its top bit is the slice carry. No sign extension anywhere.
- Reset, from any state including mid-RUN: state=IDLE, idx=0, carry register=0. Outputs busy=0, done=0, result=0, Cout=0, overflow=0. Any operation in progress is discarded and no done pulse is produced.
- rst has priority over start in the same cycle.

## Timing
- Cycle numbering: start=1 is sampled at edge e0.
  - After e0: busy=1.
  - Edges e1 to eN process slices 0 to N-1, least significant first.
  - After eN: busy=0 and done=1 for one cycle, with result, Cout and overflow valid.
- Latency: done is high N+1 cycles after the start cycle (9 at defaults).
- Throughput: a new start is accepted in the DONE cycle, so one operation per N+1 cycles.
- Partial result bits are visible during RUN. Consumers qualify result with done.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Wrap with carry out: A=0x00000001, B=0xFFFFFFFF, Cin=0 -> done 9 cycles after start; result=0x00000000, Cout=1, overflow=0.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, Cin=0 -> result=0x80000000, Cout=0, overflow=1. Then A=0x80000000, B=0x80000000 -> result=0, Cout=1, overflow=1.
- Carry-in and full ripple:
  - A=0, B=0, Cin=1 -> result=0x00000001, Cout=0.
  - A=0xFFFFFFFF, B=0, Cin=1 -> result=0, Cout=1, overflow=0 (carry crosses every slice boundary).
- Start while busy: start with A=5, B=7; pulse start with A=100, B=100 at cycle 3 -> second request ignored; done once at cycle 9 with result=0x0000000C; busy low and no further done afterwards.
- Back-to-back: operation 1 (A=0x12345678, B=0x11111111) and operation 2 (A=0xFFFF0000, B=0x00010000), with start held high through operation 1's DONE cycle.
  - Operation 1: done at cycle 9, result=0x23456789.
  - Operation 2: done at cycle 18, result=0x00000000, Cout=1.
- Reset mid-operation: start, then rst=1 at cycle 4 for one cycle -> next cycle all outputs are 0 and state is IDLE; no done pulse for the aborted operation. A subsequent start with A=3, B=4 -> result=7 after 9 cycles.
